hilo_muldiv_unit: RTL

- Iterative multi-cycle multiply/divide engine that owns the HI/LO register pair of the multicycle MIPS datapath.
- Accepts operands and an op code from the datapath with a start/busy/done handshake.
- Produces {HI,LO} for mult/multu/div/divu and services mthi/mtlo writes. HI and LO are read continuously by the datapath for mfhi/mflo.
- The control FSM stalls on Busy.

---
 rtl/hilo_muldiv_unit_if.sv | 28 ++
 rtl/hilo_muldiv_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: request/result bundle between the datapath and the
// HI/LO multiply/divide unit. The datapath is the master and the unit the slave.
interface hilo_muldiv_unit_if #(
    parameter int DATA_SIZE = 32
) ();
    logic                 Start;
    logic [1:0]           Op;
    logic [DATA_SIZE-1:0] SrcA;
    logic [DATA_SIZE-1:0] SrcB;
    logic                 HIWrite;
    logic                 LOWrite;
    logic [DATA_SIZE-1:0] WData;
    logic [DATA_SIZE-1:0] HI;
    logic [DATA_SIZE-1:0] LO;
    logic                 Busy;
    logic                 Done;
    logic                 Unvalid;

    modport master (
        output Start, Op, SrcA, SrcB, HIWrite, LOWrite, WData,
        input  HI, LO, Busy, Done, Unvalid
    );

    modport slave (
        input  Start, Op, SrcA, SrcB, HIWrite, LOWrite, WData,
        output HI, LO, Busy, Done, Unvalid
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide engine owning the HI/LO pair.
// Op: 0=mult, 1=multu, 2=div, 3=divu. Work is done on operand magnitudes
// (shift-add multiply, restoring divide), and the signs are applied in the
// single FIX cycle that also writes HI/LO.
// Optional build macro MULDIV_EARLY_TERM_EN: multiplies leave CALC as soon as
// no multiplier bits remain, and the product is realigned in FIX.
module hilo_muldiv_unit #(
    parameter int DATA_SIZE = 32,
    parameter int CNT_SIZE  = 6
) (
    input  logic              CLK,
    input  logic              RST,
    hilo_muldiv_unit_if.slave bus
);
    localparam int N = DATA_SIZE;
    localparam logic [CNT_SIZE-1:0] LAST_CNT = CNT_SIZE'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, ZERO} state_t;

    // Two's-complement negation of a word when neg is set
    function automatic logic [N-1:0] neg_word(input logic [N-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Two's-complement negation of a double word when neg is set
    function automatic logic [2*N-1:0] neg_dword(input logic [2*N-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t              state, state_nxt;
    logic                busy;
    logic                start_ok;
    logic                div_zero;
    logic                signed_op;
    logic signed [N-1:0] src_a_s, src_b_s;
    logic                in_sign_a, in_sign_b;
    logic [N-1:0]        in_mag_a, in_mag_b;

    logic [CNT_SIZE-1:0] cnt;
    logic                is_div_r;
    logic                sign_a, sign_b;
    logic [N-1:0]        opnd_r;     // multiplicand for multiply, divisor for divide
    logic [2*N-1:0]      acc;        // {partial product | remainder, multiplier | dividend/quotient}
    logic                last_iter;

    logic [N:0]          mul_sum;
    logic [N:0]          rem_shift;
    logic [N:0]          div_trial;
    logic [2*N-1:0]      acc_step;

    logic [2*N-1:0]      prod;
    logic [2*N-1:0]      prod_s;
    logic [N-1:0]        res_hi, res_lo;

    logic [N-1:0]        hi_r, lo_r;
    logic                done_r, unvalid_r;

`ifdef MULDIV_EARLY_TERM_EN
    localparam logic [CNT_SIZE-1:0] N_CNT = CNT_SIZE'(N);
    logic [N-1:0]        mplr_rem;   // multiplier bits not yet consumed
`endif

    assign start_ok  = bus.Start && (state == IDLE);
    assign div_zero  = bus.Op[1] && (bus.SrcB == '0);
    assign signed_op = ~bus.Op[0];
    assign src_a_s   = bus.SrcA;
    assign src_b_s   = bus.SrcB;
    assign in_sign_a = signed_op && (src_a_s < 0);
    assign in_sign_b = signed_op && (src_b_s < 0);
    assign in_mag_a  = neg_word(bus.SrcA, in_sign_a);
    assign in_mag_b  = neg_word(bus.SrcB, in_sign_b);

`ifdef MULDIV_EARLY_TERM_EN
    assign last_iter = (cnt == LAST_CNT) || (!is_div_r && ((mplr_rem >> 1) == '0));
`else
    assign last_iter = (cnt == LAST_CNT);
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and Busy
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.Start) state_nxt = div_zero ? ZERO : CALC;
            end
            CALC:    if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            ZERO:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd_r} : '0);
        rem_shift = {acc[2*N-1:N], acc[N-1]};
        div_trial = rem_shift - {1'b0, opnd_r};
        if (is_div_r) begin
            if (!div_trial[N]) acc_step = {div_trial[N-1:0], acc[N-2:0], 1'b1};
            else               acc_step = {rem_shift[N-1:0], acc[N-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[N-1:1]};
        end
    end

    // Sign fix-up of the finished magnitude result
    always_comb begin
`ifdef MULDIV_EARLY_TERM_EN
        prod = acc >> (N_CNT - cnt);
`else
        prod = acc;
`endif
        prod_s = neg_dword(prod, sign_a ^ sign_b);
        if (is_div_r) begin
            res_lo = neg_word(acc[N-1:0], sign_a ^ sign_b);
            res_hi = neg_word(acc[2*N-1:N], sign_a);
        end else begin
            res_lo = prod_s[N-1:0];
            res_hi = prod_s[2*N-1:N];
        end
    end

    // Operand capture on Start, then one iteration per CALC cycle
    always_ff @(posedge CLK) begin
        if (start_ok) begin
            is_div_r <= bus.Op[1];
            sign_a   <= in_sign_a;
            sign_b   <= in_sign_b;
            opnd_r   <= bus.Op[1] ? in_mag_b : in_mag_a;
            acc      <= {{N{1'b0}}, (bus.Op[1] ? in_mag_a : in_mag_b)};
            cnt      <= '0;
`ifdef MULDIV_EARLY_TERM_EN
            mplr_rem <= in_mag_b;
`endif
        end else if (state == CALC) begin
            acc      <= acc_step;
            cnt      <= cnt + 1'b1;
`ifdef MULDIV_EARLY_TERM_EN
            mplr_rem <= mplr_rem >> 1;
`endif
        end
    end

    // HI/LO ownership and the Done/Unvalid pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hi_r      <= '0;
            lo_r      <= '0;
            done_r    <= 1'b0;
            unvalid_r <= 1'b0;
        end else begin
            done_r    <= (state == FIX) || (state == ZERO);
            unvalid_r <= (state == ZERO);
            if (state == FIX) begin
                hi_r <= res_hi;
                lo_r <= res_lo;
            end else if (state == IDLE) begin
                if (bus.HIWrite) hi_r <= bus.WData;
                if (bus.LOWrite) lo_r <= bus.WData;
            end
        end
    end

    assign bus.HI      = hi_r;
    assign bus.LO      = lo_r;
    assign bus.Busy    = busy;
    assign bus.Done    = done_r;
    assign bus.Unvalid = unvalid_r;
endmodule
